// File: rtl/instruction_set_pkg.sv
// Shared instruction-set types: operation encoding and the architectural flags layout.
package instruction_set_pkg;

  typedef enum logic [3:0] {
    OP_MOVE, OP_LIL, OP_LIH, OP_ADD, OP_ADC, OP_SUB, OP_AND, OP_OR,
    OP_XOR,  OP_NOT, OP_ROL, OP_ROR, OP_MUL, OP_DIV, OP_MOD, OP_NOP
  } operation_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic negative;
    logic overflow;
  } flags_s;

endpackage

// File: rtl/alu_issue_controller_if.sv
// Bundle between the issue controller (slave) and its surroundings (master):
// instruction handshake, ALU drive/return, retirement status and debug read port.
interface alu_issue_controller_if #(
  parameter int DataWidth      = 16,
  parameter int ImmediateWidth = 8,
  parameter int RegAddrWidth   = 3
) ();

  logic                            instr_valid;
  logic                            instr_ready;
  instruction_set_pkg::operation_e instr_op;
  logic [RegAddrWidth-1:0]         instr_src;
  logic [RegAddrWidth-1:0]         instr_dest;
  logic [ImmediateWidth-1:0]       instr_imm;

  instruction_set_pkg::operation_e alu_operation;
  instruction_set_pkg::flags_s     alu_in_flags;
  logic [ImmediateWidth-1:0]       alu_in_imm;
  logic [DataWidth-1:0]            alu_in_src;
  logic [DataWidth-1:0]            alu_in_dest;
  instruction_set_pkg::flags_s     alu_out_flags;
  logic [DataWidth-1:0]            alu_out_dest;

  logic                            done;
  logic [DataWidth-1:0]            result;
  logic                            div0_error;
  instruction_set_pkg::flags_s     flags_out;
  logic [RegAddrWidth-1:0]         rd_addr;
  logic [DataWidth-1:0]            rd_data;

  modport master (
    output instr_valid, instr_op, instr_src, instr_dest, instr_imm,
    output alu_out_flags, alu_out_dest, rd_addr,
    input  instr_ready, alu_operation, alu_in_flags, alu_in_imm, alu_in_src, alu_in_dest,
    input  done, result, div0_error, flags_out, rd_data
  );

  modport slave (
    input  instr_valid, instr_op, instr_src, instr_dest, instr_imm,
    input  alu_out_flags, alu_out_dest, rd_addr,
    output instr_ready, alu_operation, alu_in_flags, alu_in_imm, alu_in_src, alu_in_dest,
    output done, result, div0_error, flags_out, rd_data
  );

endinterface

// File: rtl/alu_issue_controller.sv
// Three-cycle IDLE/EXEC/WRITE sequencer around an external combinational ALU.
// Optional divide-by-zero trap is enabled by defining ALU_DIV0_TRAP_EN.
module alu_issue_controller
  import instruction_set_pkg::*;
#(
  parameter int DataWidth      = 16,
  parameter int ImmediateWidth = 8,
  parameter int RegAddrWidth   = 3
) (
  input logic                   clock,
  input logic                   reset,
  alu_issue_controller_if.slave bus
);

  localparam int NumRegs = 2 ** RegAddrWidth;

  typedef enum logic [1:0] {IDLE, EXEC, WRITE} state_e;

  state_e                    state_reg;
  state_e                    state_next;
  logic [DataWidth-1:0]      regs [NumRegs];
  flags_s                    flags_reg;
  flags_s                    flags_new_reg;
  operation_e                op_reg;
  logic [RegAddrWidth-1:0]   dest_idx_reg;
  logic [ImmediateWidth-1:0] imm_reg;
  logic [DataWidth-1:0]      op_src_reg;
  logic [DataWidth-1:0]      op_dest_reg;
  logic [DataWidth-1:0]      result_reg;
  logic                      trap_reg;
  logic                      commit;
  logic [NumRegs-1:0]        reg_we;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.instr_valid) state_next = EXEC;
      EXEC:    state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.instr_ready = 1'b0;
    bus.done        = 1'b0;
    bus.div0_error  = 1'b0;
    bus.result      = result_reg;
    case (state_reg)
      IDLE:  bus.instr_ready = 1'b1;
      WRITE: begin
        bus.done       = 1'b1;
        bus.div0_error = trap_reg;
        if (trap_reg) bus.result = '0;
      end
      default: ;
    endcase
  end

  // Operand and result registers; ALU drive below always comes from these.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_reg        <= OP_MOVE;
      dest_idx_reg  <= '0;
      imm_reg       <= '0;
      op_src_reg    <= '0;
      op_dest_reg   <= '0;
      result_reg    <= '0;
      flags_new_reg <= '0;
      flags_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: if (bus.instr_valid) begin
          op_reg       <= bus.instr_op;
          dest_idx_reg <= bus.instr_dest;
          imm_reg      <= bus.instr_imm;
          op_src_reg   <= regs[bus.instr_src];
          op_dest_reg  <= regs[bus.instr_dest];
        end
        EXEC: begin
          result_reg    <= bus.alu_out_dest;
          flags_new_reg <= bus.alu_out_flags;
        end
        WRITE: if (commit) flags_reg <= flags_new_reg;
        default: ;
      endcase
    end
  end

`ifdef ALU_DIV0_TRAP_EN
  // Trap decision is taken on the same edge the ALU result is captured.
  always_ff @(posedge clock) begin
    if (reset) begin
      trap_reg <= 1'b0;
    end else if (state_reg == EXEC) begin
      trap_reg <= ((op_reg == OP_DIV) || (op_reg == OP_MOD)) && (op_src_reg == '0);
    end else if (state_reg == IDLE) begin
      trap_reg <= 1'b0;
    end
  end
`else
  assign trap_reg = 1'b0;
`endif

  assign commit = (state_reg == WRITE) && !trap_reg;

  for (genvar gi = 0; gi < NumRegs; gi++) begin : g_we
    assign reg_we[gi] = commit && (dest_idx_reg == RegAddrWidth'(gi));
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NumRegs; i++) begin
      if (reset) begin
        regs[i] <= '0;
      end else if (reg_we[i]) begin
        regs[i] <= result_reg;
      end
    end
  end

  assign bus.alu_operation = op_reg;
  assign bus.alu_in_flags  = flags_reg;
  assign bus.alu_in_imm    = imm_reg;
  assign bus.alu_in_src    = op_src_reg;
  assign bus.alu_in_dest   = op_dest_reg;
  assign bus.flags_out     = flags_reg;
  assign bus.rd_data       = regs[bus.rd_addr];

endmodule

// File: tb/tb_alu_issue_controller.sv
// Scoreboard bench for alu_issue_controller with a behavioural stand-in ALU.
module tb_alu_issue_controller;
  import instruction_set_pkg::*;

  typedef struct packed {
    flags_s      flags;
    logic [15:0] data;
  } alu_ret_t;

  typedef struct {
    logic [15:0] data;
    logic        div0;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_issue_controller_if bus ();

  alu_issue_controller dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          done_count = 0;
  int          last_wait = 0;
  logic [15:0] model_regs [8];
  flags_s      model_flags;
  alu_ret_t    alu_now;

  // Stand-in ALU: ADC keeps carry, ROL rotates through carry, DIV/MOD by zero give all ones.
  function automatic alu_ret_t alu_f(operation_e op, logic [15:0] src, logic [15:0] dest,
                                     logic [7:0] imm, flags_s fin);
    alu_ret_t    r;
    logic [16:0] sum;
    r.flags = fin;
    r.data  = dest;
    case (op)
      OP_MOVE: r.data = src;
      OP_LIL:  r.data = {dest[15:8], imm};
      OP_LIH:  r.data = {imm, dest[7:0]};
      OP_ADD: begin
        sum          = {1'b0, dest} + {1'b0, src};
        r.data       = sum[15:0];
        r.flags.carry = sum[16];
        r.flags.zero  = (sum[15:0] == 16'h0000);
      end
      OP_ADC: begin
        r.data       = dest + src + {15'd0, fin.carry};
        r.flags.zero = (r.data == 16'h0000);
      end
      OP_ROL: begin
        r.data        = {src[14:0], fin.carry};
        r.flags.carry = src[15];
        r.flags.zero  = (r.data == 16'h0000);
      end
      OP_DIV:  r.data = (src == 16'h0000) ? 16'hFFFF : dest / src;
      OP_MOD:  r.data = (src == 16'h0000) ? 16'hFFFF : dest % src;
      default: ;
    endcase
    return r;
  endfunction

  assign alu_now = alu_f(bus.alu_operation, bus.alu_in_src, bus.alu_in_dest,
                         bus.alu_in_imm, bus.alu_in_flags);
  assign bus.alu_out_flags = alu_now.flags;
  assign bus.alu_out_dest  = alu_now.data;

  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      done_count++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL retire_unexpected: done=1 with nothing outstanding, result=%h", bus.result);
      end else begin
        mon_e = sb.pop_front();
        if (bus.result !== mon_e.data) begin
          errors++;
          $display("FAIL retire_result: got %h expected %h", bus.result, mon_e.data);
        end
        checks++;
        if (bus.div0_error !== mon_e.div0) begin
          errors++;
          $display("FAIL retire_div0: got %b expected %b", bus.div0_error, mon_e.div0);
        end
        $display("retire: result=%h div0=%b", bus.result, bus.div0_error);
      end
    end else if (!rst) begin
      checks++;
      if (bus.div0_error !== 1'b0) begin
        errors++;
        $display("FAIL div0_idle: div0_error=%b outside retirement", bus.div0_error);
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < 8; i++) model_regs[i] = 16'h0000;
    model_flags = '0;
    sb.delete();
  endtask

  task automatic issue(input operation_e op, input int src, input int dest,
                       input logic [7:0] imm, input bit hold);
    int       n;
    alu_ret_t r;
    exp_t     e;
    logic     trap;
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr_op    = op;
    bus.instr_src   = src[2:0];
    bus.instr_dest  = dest[2:0];
    bus.instr_imm   = imm;
    n = 0;
    while (bus.instr_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL issue_timeout: instr_ready=%b after %0d cycles, required 1", bus.instr_ready, n);
      bus.instr_valid = 1'b0;
      return;
    end
    r    = alu_f(op, model_regs[src], model_regs[dest], imm, model_flags);
    trap = 1'b0;
`ifdef ALU_DIV0_TRAP_EN
    trap = ((op == OP_DIV) || (op == OP_MOD)) && (model_regs[src] == 16'h0000);
`endif
    e.data = trap ? 16'h0000 : r.data;
    e.div0 = trap;
    sb.push_back(e);
    if (!trap) begin
      model_regs[dest] = r.data;
      model_flags      = r.flags;
    end
    last_wait = n;
    $display("issue: op=%s src=%0d dest=%0d imm=%h wait=%0d", op.name(), src, dest, imm, n);
    @(posedge clk);
    #1;
    if (!hold) bus.instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL retire_timeout: %0d instructions outstanding, required 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    checks++;
    if (bus.instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", bus.instr_ready);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b expected 0", bus.done);
    end
    checks++;
    if (bus.flags_out.carry !== 1'b0) begin
      errors++;
      $display("FAIL reset_carry: got %b expected 0", bus.flags_out.carry);
    end
    for (int a = 0; a < 8; a++) begin
      bus.rd_addr = a[2:0];
      #1;
      checks++;
      if (bus.rd_data !== 16'h0000) begin
        errors++;
        $display("FAIL reset_reg%0d: got %h expected 0000", a, bus.rd_data);
      end
    end
  endtask

  task automatic test_lil();
    issue(OP_LIL, 0, 1, 8'h05, 1'b0);
    bus.rd_addr = 3'd1;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL lil_exec_done: got %b expected 0", bus.done);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.result !== 16'h0005) begin
      errors++;
      $display("FAIL lil_write: done=%b result=%h expected done=1 result=0005", bus.done, bus.result);
    end
    checks++;
    if (bus.rd_data !== 16'h0000) begin
      errors++;
      $display("FAIL lil_early_write: rd_data=%h expected 0000 before writeback", bus.rd_data);
    end
    @(negedge clk);
    checks++;
    if (bus.rd_data !== 16'h0005) begin
      errors++;
      $display("FAIL lil_reg1: got %h expected 0005", bus.rd_data);
    end
  endtask

  task automatic test_rol_adc();
    issue(OP_LIH, 0, 2, 8'h80, 1'b0);
    wait_idle();
    bus.rd_addr = 3'd2;
    #1;
    checks++;
    if (bus.rd_data !== 16'h8000 || bus.flags_out.carry !== 1'b0) begin
      errors++;
      $display("FAIL setup_r2: r2=%h carry=%b expected 8000/0", bus.rd_data, bus.flags_out.carry);
    end
    issue(OP_ROL, 2, 2, 8'h00, 1'b0);
    wait_idle();
    checks++;
    if (bus.rd_data !== 16'h0000 || bus.flags_out.carry !== 1'b1) begin
      errors++;
      $display("FAIL rol: r2=%h carry=%b expected 0000/1", bus.rd_data, bus.flags_out.carry);
    end
    issue(OP_ADC, 2, 2, 8'h00, 1'b0);
    wait_idle();
    checks++;
    if (bus.rd_data !== 16'h0001 || bus.flags_out.carry !== 1'b1) begin
      errors++;
      $display("FAIL adc: r2=%h carry=%b expected 0001/1", bus.rd_data, bus.flags_out.carry);
    end
    checks++;
    if (bus.flags_out !== model_flags) begin
      errors++;
      $display("FAIL adc_flags: got %b expected %b", bus.flags_out, model_flags);
    end
  endtask

  task automatic test_back_to_back();
    int start;
    start = done_count;
    issue(OP_MOVE, 1, 6, 8'h00, 1'b1);
    issue(OP_MOVE, 6, 7, 8'h00, 1'b0);
    checks++;
    if (last_wait != 2) begin
      errors++;
      $display("FAIL b2b_ready_low: ready low %0d cycles, expected 2", last_wait);
    end
    wait_idle();
    repeat (4) @(negedge clk);
    checks++;
    if (done_count - start != 2) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d pulses expected 2", done_count - start);
    end
    bus.rd_addr = 3'd7;
    #1;
    checks++;
    if (bus.rd_data !== 16'h0005) begin
      errors++;
      $display("FAIL b2b_reg7: got %h expected 0005", bus.rd_data);
    end
  endtask

  task automatic test_reset_in_exec();
    int start;
    issue(OP_LIL, 0, 3, 8'h7F, 1'b0);
    start = done_count;
    rst = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    checks++;
    if (bus.instr_ready !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL rst_exec_state: ready=%b done=%b expected 1/0", bus.instr_ready, bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (done_count != start) begin
      errors++;
      $display("FAIL rst_exec_done: %0d pulses after reset, expected 0", done_count - start);
    end
    bus.rd_addr = 3'd3;
    #1;
    checks++;
    if (bus.rd_data !== 16'h0000) begin
      errors++;
      $display("FAIL rst_exec_reg3: got %h expected 0000", bus.rd_data);
    end
  endtask

  task automatic test_div0();
    logic [15:0] want_r4;
    issue(OP_LIL, 0, 4, 8'h10, 1'b0);
    wait_idle();
    issue(OP_ADD, 5, 5, 8'h00, 1'b0);
    wait_idle();
    issue(OP_DIV, 5, 4, 8'h00, 1'b0);
    wait_idle();
`ifdef ALU_DIV0_TRAP_EN
    want_r4 = 16'h0010;
`else
    want_r4 = 16'hFFFF;
`endif
    bus.rd_addr = 3'd4;
    #1;
    checks++;
    if (bus.rd_data !== want_r4) begin
      errors++;
      $display("FAIL div0_reg4: got %h expected %h", bus.rd_data, want_r4);
    end
    checks++;
    if (bus.flags_out !== 4'b0100) begin
      errors++;
      $display("FAIL div0_flags: got %b expected 0100", bus.flags_out);
    end
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr_op    = OP_NOP;
    bus.instr_src   = 3'd0;
    bus.instr_dest  = 3'd0;
    bus.instr_imm   = 8'h00;
    bus.rd_addr     = 3'd0;
    model_clear();
    test_reset();
    test_lil();
    test_rol_adc();
    test_back_to_back();
    test_reset_in_exec();
    test_div0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
